// File: rtl/sdio_tx_packer.sv
// Packs 8/16/32-bit uDMA elements little-endian into 32-bit words and buffers them for sdio_txrx (SDIO_TX_PACKER_BSWAP_EN: big-endian words).
// Latency: a word is pushed the cycle after its last byte is accepted; out_valid_o follows one cycle later.
// Backpressure: udma_ready_o drops while 4+ bytes are staged or the byte budget is spent; staging stalls while the FIFO is full.
module sdio_tx_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter int LOG_DEPTH  = $clog2(FIFO_DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 clr_i,
    input  logic                 start_i,
    input  logic [17:0]          total_bytes_i,
    input  logic [31:0]          udma_data_i,
    input  logic [1:0]           udma_datasize_i,
    input  logic                 udma_valid_i,
    output logic                 udma_ready_o,
    output logic [31:0]          out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [LOG_DEPTH:0]   level_o,
    output logic                 busy_o,
    output logic                 done_o
);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_e;

    state_e               state_q;
    logic [17:0]          rem_q, rem_d;
    logic [55:0]          stage_q, stage_d;
    logic [2:0]           held_q, held_d;
    logic                 done_q;
    logic [31:0]          mem_q [FIFO_DEPTH];
    logic [LOG_DEPTH-1:0] wptr_q, rptr_q;
    logic [LOG_DEPTH:0]   count_q;

    logic        fill, fifo_full, fifo_empty, pop, accept, push_req, push;
    logic [2:0]  elem_bytes, n_bytes, held_base;
    logic [31:0] keep_mask, push_word;
    logic [55:0] shifted;

    always_comb begin
        fill         = (state_q == FILL);
        fifo_full    = (count_q == (LOG_DEPTH+1)'(FIFO_DEPTH));
        fifo_empty   = (count_q == '0);
        pop          = out_ready_i && !fifo_empty;
        udma_ready_o = fill && (held_q < 3'd4) && (rem_q != '0);
        accept       = udma_ready_o && udma_valid_i;
        // A partial word is flushed only once the budget is exhausted.
        push_req     = fill && ((held_q >= 3'd4) || ((rem_q == '0) && (held_q != '0)));
        push         = push_req && (!fifo_full || pop);

        case (udma_datasize_i)
            2'd0:    elem_bytes = 3'd1;
            2'd1:    elem_bytes = 3'd2;
            default: elem_bytes = 3'd4;
        endcase
        n_bytes = (rem_q < {15'd0, elem_bytes}) ? rem_q[2:0] : elem_bytes;

        case (n_bytes)
            3'd1:    keep_mask = 32'h0000_00FF;
            3'd2:    keep_mask = 32'h0000_FFFF;
            3'd3:    keep_mask = 32'h00FF_FFFF;
            default: keep_mask = 32'hFFFF_FFFF;
        endcase

        // Bytes above held_q are kept zero, so the low word doubles as the padded tail.
        shifted   = push ? (stage_q >> 32) : stage_q;
        held_base = !push ? held_q : ((held_q >= 3'd4) ? (held_q - 3'd4) : 3'd0);
        stage_d   = shifted;
        held_d    = held_base;
        rem_d     = rem_q;
        if (accept) begin
            stage_d = shifted | ({24'd0, udma_data_i & keep_mask} << {held_base, 3'b000});
            held_d  = held_base + n_bytes;
            rem_d   = rem_q - {15'd0, n_bytes};
        end

`ifdef SDIO_TX_PACKER_BSWAP_EN
        push_word = {stage_q[7:0], stage_q[15:8], stage_q[23:16], stage_q[31:24]};
`else
        push_word = stage_q[31:0];
`endif
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            stage_q <= '0;
            held_q  <= '0;
            done_q  <= 1'b0;
        end else if (clr_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            stage_q <= '0;
            held_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        rem_q   <= total_bytes_i;
                        stage_q <= '0;
                        held_q  <= '0;
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    stage_q <= stage_d;
                    held_q  <= held_d;
                    rem_q   <= rem_d;
                    // The last word may already be popped in the cycle staging empties.
                    if ((rem_q == '0) && (held_q == '0)) begin
                        if (pop && (count_q == (LOG_DEPTH+1)'(1))) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && (count_q == (LOG_DEPTH+1)'(1))) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else if (fifo_empty) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (clr_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + LOG_DEPTH'(1);
            if (pop)  rptr_q <= rptr_q + LOG_DEPTH'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (LOG_DEPTH+1)'(1);
                2'b01:   count_q <= count_q - (LOG_DEPTH+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !clr_i) mem_q[wptr_q] <= push_word;
    end

    assign out_valid_o = !fifo_empty;
    assign out_data_o  = fifo_empty ? 32'd0 : mem_q[rptr_q];
    assign level_o     = count_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;

endmodule

// File: tb/tb_sdio_tx_packer.sv
// Bench for sdio_tx_packer: directed scenarios plus randomized transfers checked against a byte-queue model.
module tb_sdio_tx_packer;
    localparam int DEPTH = 4;
    localparam int LOG   = 2;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b0, clr_i = 1'b0, start_i = 1'b0;
    logic [17:0] total_bytes_i = '0;
    logic [31:0] udma_data_i = '0;
    logic [1:0]  udma_datasize_i = '0;
    logic        udma_valid_i = 1'b0, udma_ready_o;
    logic [31:0] out_data_o;
    logic        out_valid_o, out_ready_i = 1'b0;
    logic [LOG:0] level_o;
    logic        busy_o, done_o;

    always #5 clk = ~clk;

    sdio_tx_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rstn_i(rstn_i), .clr_i(clr_i), .start_i(start_i),
        .total_bytes_i(total_bytes_i), .udma_data_i(udma_data_i),
        .udma_datasize_i(udma_datasize_i), .udma_valid_i(udma_valid_i),
        .udma_ready_o(udma_ready_o), .out_data_o(out_data_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .level_o(level_o), .busy_o(busy_o), .done_o(done_o)
    );

    int checks = 0, failures = 0;
    logic [1:0]  el_size[$];
    logic [31:0] el_data[$];
    logic [31:0] exp_q[$];
    int el_idx, acc_bytes, cur_total, popped, done_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
    endfunction

    function automatic logic [31:0] ord(input logic [31:0] w);
`ifdef SDIO_TX_PACKER_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic add_el(input logic [1:0] s, input logic [31:0] d);
        el_size.push_back(s);
        el_data.push_back(d);
    endtask

    task automatic clear_els();
        el_size.delete();
        el_data.delete();
        exp_q.delete();
    endtask

    // Reference: flatten elements into a byte stream, cut at the budget, zero-pad, group by 4.
    function automatic void build_expected(input int total);
        logic [7:0] bq[$];
        logic [31:0] d;
        exp_q.delete();
        for (int i = 0; i < el_size.size() && bq.size() < total; i++) begin
            d = el_data[i];
            for (int b = 0; b < nbytes(el_size[i]) && bq.size() < total; b++)
                bq.push_back(d[8*b +: 8]);
        end
        while (bq.size() % 4 != 0) bq.push_back(8'h00);
        for (int i = 0; i < bq.size(); i += 4)
            exp_q.push_back(ord({bq[i+3], bq[i+2], bq[i+1], bq[i]}));
    endfunction

    task automatic gen_random(input int total);
        int sum = 0;
        clear_els();
        while (sum < total) begin
            logic [1:0] s = 2'($urandom_range(0, 3));
            add_el(s, $urandom);
            sum += nbytes(s);
        end
        add_el(2'd2, $urandom);
    endtask

    // Entered and left at posedge+1.
    task automatic start_xfer(input int total);
        cur_total = total; el_idx = 0; acc_bytes = 0; popped = 0; done_cnt = 0;
        start_i = 1'b1;
        total_bytes_i = 18'(total);
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("start_busy", busy_o, 1);
        chk("start_ready", udma_ready_o, 1);
    endtask

    task automatic pump(input int pop_pct, input int max_cyc, input bit until_done);
        int cyc = 0;
        int held, nb, take;
        while (1) begin
            if (until_done && exp_q.size() == 0) break;
            if (cyc >= max_cyc) begin
                if (until_done) chk("timeout_words_left", exp_q.size(), 0);
                break;
            end
            udma_valid_i = (el_idx < el_size.size()) && ($urandom_range(3) != 0);
            if (el_idx < el_size.size()) begin
                udma_data_i = el_data[el_idx];
                udma_datasize_i = el_size[el_idx];
            end
            out_ready_i = ($urandom_range(99) < pop_pct);
            @(negedge clk);
            held = acc_bytes - 4 * (int'(level_o) + popped);
            chk("ready_rule", udma_ready_o, (held < 4) && (acc_bytes < cur_total));
            if (udma_valid_i && udma_ready_o) begin
                nb = nbytes(el_size[el_idx]);
                take = (cur_total - acc_bytes < nb) ? cur_total - acc_bytes : nb;
                acc_bytes += take;
                el_idx++;
            end
            if (out_ready_i && out_valid_o) begin
                if (exp_q.size() == 0) chk("extra_word", out_data_o, 32'hDEAD_BEEF);
                else chk("word", out_data_o, exp_q.pop_front());
                popped++;
            end
            if (done_o) done_cnt++;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic finish_xfer();
        udma_valid_i = 1'b0;
        out_ready_i = 1'b0;
        chk("done_pulse", done_o, 1);
        chk("done_not_early", done_cnt, 0);
        chk("busy_after", busy_o, 0);
        @(posedge clk); #1;
        chk("done_single", done_o, 0);
        chk("empty_after", out_valid_o, 0);
    endtask

    task automatic run(input int total, input int pop_pct, input bit use_model);
        if (use_model) build_expected(total);
        start_xfer(total);
        pump(pop_pct, 3000, 1);
        finish_xfer();
    endtask

    initial begin
        #3;
        chk("rst_ready", udma_ready_o, 0);
        chk("rst_valid", out_valid_o, 0);
        chk("rst_data", out_data_o, 0);
        chk("rst_level", level_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        @(posedge clk); #1;
        rstn_i = 1'b1;
        @(posedge clk); #1;

        // Byte packing
        clear_els();
        for (int i = 1; i <= 8; i++) add_el(2'd0, 32'(i * 8'h11));
        exp_q.push_back(ord(32'h4433_2211));
        exp_q.push_back(ord(32'h8877_6655));
        run(8, 100, 0);

        // Tail padding, excess bytes dropped
        clear_els();
        add_el(2'd2, 32'hAABB_CCDD);
        add_el(2'd2, 32'h1122_3344);
        exp_q.push_back(ord(32'hAABB_CCDD));
        exp_q.push_back(ord(32'h0000_3344));
        run(6, 100, 0);

        // Misaligned mix
        clear_els();
        add_el(2'd0, 32'hFFFF_FF01);
        add_el(2'd2, 32'h0504_0302);
        add_el(2'd1, 32'hFFFF_0706);
        exp_q.push_back(ord(32'h0403_0201));
        exp_q.push_back(ord(32'h0007_0605));
        run(7, 100, 0);

`ifdef SDIO_TX_PACKER_BSWAP_EN
        clear_els();
        add_el(2'd0, 32'h11); add_el(2'd0, 32'h22); add_el(2'd0, 32'h33); add_el(2'd0, 32'h44);
        exp_q.push_back(32'h1122_3344);
        run(4, 100, 0);
        clear_els();
        add_el(2'd0, 32'h11); add_el(2'd0, 32'h22); add_el(2'd0, 32'h33);
        exp_q.push_back(32'h1122_3300);
        run(3, 100, 0);
`endif

        // Backpressure: FIFO fills, four bytes left staged
        clear_els();
        for (int i = 0; i < 6; i++) add_el(2'd2, 32'hC0DE_0000 + 32'(i * 32'h0101));
        build_expected(24);
        start_xfer(24);
        pump(0, 30, 0);
        chk("bp_accepted", el_idx, 5);
        chk("bp_level", level_o, 4);
        chk("bp_ready", udma_ready_o, 0);
        pump(100, 3000, 1);
        finish_xfer();

        // Abort with three words buffered
        gen_random(24);
        for (int i = 0; i < 6; i++) begin el_size[i] = 2'd2; end
        build_expected(24);
        start_xfer(24);
        for (int k = 0; k < 40 && level_o != 3; k++) pump(0, 1, 0);
        chk("abort_setup_level", level_o, 3);
        udma_valid_i = 1'b0;
        clr_i = 1'b1;
        @(posedge clk); #1;
        clr_i = 1'b0;
        chk("abort_level", level_o, 0);
        chk("abort_valid", out_valid_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_ready", udma_ready_o, 0);
        done_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done_o) done_cnt++;
        end
        @(posedge clk); #1;
        chk("abort_no_done", done_cnt, 0);
        gen_random(13);
        run(13, 70, 1);

        // Randomized transfers
        for (int t = 0; t < 10; t++) begin
            int total = $urandom_range(1, 40);
            gen_random(total);
            run(total, $urandom_range(20, 100), 1);
        end

        // Asynchronous reset mid-transfer
        gen_random(40);
        build_expected(40);
        start_xfer(40);
        pump(100, 8, 0);
        #2 rstn_i = 1'b0;
        #1;
        chk("arst_ready", udma_ready_o, 0);
        chk("arst_valid", out_valid_o, 0);
        chk("arst_data", out_data_o, 0);
        chk("arst_level", level_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_done", done_o, 0);
        udma_valid_i = 1'b0;
        out_ready_i = 1'b0;
        @(posedge clk); #1;
        rstn_i = 1'b1;
        @(posedge clk); #1;
        gen_random(21);
        run(21, 100, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
